pc_fetch_unit: RTL and testbench

//  PC register plus instruction-fetch sequencer, directly downstream of the next-PC logic.

---
 rtl/pc_fetch_unit.sv | 60 ++++++
 tb/tb_pc_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and single-outstanding instruction fetch sequencer
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        misalign,
   output logic [31:0] instret
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, ERR} state_t;
   state_t state, state_nxt;
   logic   drop_pend;
   logic   take;
   logic   handshake;
   assign imem_req   = state == REQ;
   assign imem_addr  = pc;
   assign inst_valid = state == VALID;
   assign misalign   = state == ERR;
   assign take       = state == WAIT && imem_rvalid && !drop_pend;
   assign handshake  = state == VALID && inst_ready;
   // next state: a misaligned npc parks the unit in ERR until reset
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE ? REQ :
                  (state == REQ && imem_gnt) ? WAIT :
                  take ? VALID :
                  handshake ? (npc[1:0] == 2'b00 ? REQ : ERR) :
                  state;
   end
   // state, PC, instruction and retire counter; a response still in flight at reset is dropped later
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         inst      <= NOP_INST;
         instret   <= 32'd0;
         drop_pend <= state == WAIT && !imem_rvalid;
      end else begin
         state <= state_nxt;
         if (state == WAIT && imem_rvalid && drop_pend) drop_pend <= 1'b0;
         if (take) inst <= imem_rdata;
         if (handshake) begin
            instret <= instret + 32'd1;
            pc      <= npc;
            inst    <= NOP_INST;
         end
      end
   end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized fetch traffic against a transaction-level model
module tb_pc_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] npc = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        misalign;
   logic [31:0] instret;
   int n_cmp = 0;
   int n_bad = 0;

   pc_fetch_unit dut (
      .clk(clk), .rst(rst), .npc(npc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .pc(pc), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .misalign(misalign), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   initial begin
      logic [31:0] model_pc;
      logic [31:0] model_cnt;
      logic [31:0] raddr;
      logic [31:0] hold_pc;
      logic [31:0] hold_inst;
      logic        pend;
      logic        hs;
      int          lat;
      int          done;
      int          cyc;
      // 1: reset, then fetch at address 0 with immediate grant
      step();
      step();
      rst = 1'b0;
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst, 32'h13);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_instret", instret, 32'd0);
      step();
      chk("t1_req", {31'd0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'h0);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("t1_wait_valid", {31'd0, inst_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata = 32'h0050_0093;
      step();
      imem_rvalid = 1'b0;
      chk("t1_valid", {31'd0, inst_valid}, 32'd1);
      chk("t1_inst", inst, 32'h0050_0093);
      chk("t1_pc", pc, 32'h0);
      // 2: decode stalls with npc wandering, then accepts npc=8
      for (int i = 0; i < 5; i++) begin
         npc = $urandom;
         step();
         chk("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
         chk("t2_hold_pc", pc, 32'h0);
         chk("t2_hold_inst", inst, 32'h0050_0093);
      end
      npc = 32'h8;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t2_pc", pc, 32'h8);
      chk("t2_instret", instret, 32'd1);
      chk("t2_req", {31'd0, imem_req}, 32'd1);
      chk("t2_addr", imem_addr, 32'h8);
      // 3: grant withheld 4 cycles with stray responses while requesting
      for (int i = 0; i < 4; i++) begin
         imem_rvalid = i[0];
         imem_rdata = 32'hBAD0_0000 | i;
         step();
         chk("t3_req", {31'd0, imem_req}, 32'd1);
         chk("t3_addr", imem_addr, 32'h8);
      end
      imem_rvalid = 1'b0;
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      step();
      chk("t3_wait", {31'd0, inst_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      imem_rvalid = 1'b0;
      chk("t3_inst", inst, 32'h1234_5678);
      chk("t3_valid", {31'd0, inst_valid}, 32'd1);
      npc = 32'h10;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t3_addr_next", imem_addr, 32'h10);
      // 4: reset while a response is outstanding; its late arrival is discarded
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_rst_instret", instret, 32'd0);
      chk("t4_rst_pc", pc, 32'h0);
      step();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("t4_stale_valid", {31'd0, inst_valid}, 32'd0);
      chk("t4_stale_inst", inst, 32'h13);
      imem_rdata = 32'h13;
      step();
      imem_rvalid = 1'b0;
      chk("t4_valid", {31'd0, inst_valid}, 32'd1);
      chk("t4_inst", inst, 32'h13);
      // 5: misaligned npc halts fetching
      npc = 32'h102;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t5_misalign", {31'd0, misalign}, 32'd1);
      chk("t5_pc", pc, 32'h102);
      chk("t5_instret", instret, 32'd1);
      for (int i = 0; i < 8; i++) begin
         imem_gnt = 1'($urandom);
         imem_rvalid = 1'($urandom);
         inst_ready = 1'($urandom);
         step();
         chk("t5_no_req", {31'd0, imem_req}, 32'd0);
         chk("t5_no_valid", {31'd0, inst_valid}, 32'd0);
         chk("t5_sticky", {31'd0, misalign}, 32'd1);
      end
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      inst_ready = 1'b0;
      // 6a: reset coinciding with a handshake wins
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(32'h0);
      step();
      imem_rvalid = 1'b0;
      rst = 1'b1;
      inst_ready = 1'b1;
      npc = 32'h40;
      step();
      rst = 1'b0;
      inst_ready = 1'b0;
      chk("t6_rst_hs_instret", instret, 32'd0);
      chk("t6_rst_hs_pc", pc, 32'h0);
      chk("t6_rst_hs_valid", {31'd0, inst_valid}, 32'd0);
      // 6b: retire counter wraps
      step();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      step();
      imem_rvalid = 1'b0;
      force dut.instret = 32'hFFFF_FFFF;
      #1;
      release dut.instret;
      npc = 32'h4;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("t6_wrap", instret, 32'd0);
      chk("t6_wrap_pc", pc, 32'h4);
      // 6c: 100 fetches with random grant/response/accept timing
      model_pc = 32'h4;
      model_cnt = 32'd0;
      pend = 1'b0;
      lat = 0;
      done = 0;
      cyc = 0;
      raddr = 32'd0;
      while (done < 100 && cyc < 5000) begin
         cyc++;
         imem_gnt = 1'b0;
         imem_rvalid = 1'b0;
         inst_ready = 1'b0;
         hs = 1'b0;
         if (imem_req) begin
            chk("rnd_addr", imem_addr, model_pc);
            if (!pend && $urandom_range(0, 2) == 0) begin
               imem_gnt = 1'b1;
               pend = 1'b1;
               lat = $urandom_range(1, 3);
               raddr = imem_addr;
            end else if ($urandom_range(0, 3) == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata = $urandom;
            end
         end else if (pend) begin
            lat--;
            if (lat == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata = mem_word(raddr);
               pend = 1'b0;
            end
         end
         npc = $urandom;
         if (inst_valid && $urandom_range(0, 1) == 1) begin
            chk("rnd_inst", inst, mem_word(model_pc));
            chk("rnd_pc", pc, model_pc);
            npc = npc & ~32'h3;
            inst_ready = 1'b1;
            model_pc = npc;
            model_cnt++;
            done++;
            hs = 1'b1;
         end
         hold_pc = pc;
         hold_inst = inst;
         step();
         if (hs) chk("rnd_instret", instret, model_cnt);
         else if (inst_valid && !imem_rvalid) begin
            chk("rnd_stall_pc", pc, hold_pc);
            chk("rnd_stall_inst", inst, hold_inst);
         end
      end
      inst_ready = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      chk("rnd_count", done, 100);
      chk("rnd_misalign", {31'd0, misalign}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
